// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and constants for the MIPS instruction-fetch
// front end (mips_fetch_unit and its prefetch FIFO).
//   fetch_entry_t        {pc, instr} pair handed to decode
//   DEFAULT_RESET_VECTOR first fetch address after reset
//   DEFAULT_HALT_ADDR    fetch target that ends execution
//   cnt_w(depth)         width of a counter able to hold 0..depth
package mips_fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mips_fetch_unit_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO of fetch_entry_t.
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write wdata_i (ignored when full unless popping in the same cycle)
//   pop_i        drop the head entry (ignored when empty)
//   flush_i      empty the FIFO; wins over push and pop
//   rdata_o      head entry
//   count_o      occupancy 0..DEPTH
//   empty_o      occupancy == 0
//   full_o       occupancy == DEPTH
module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int         CW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  wdata_i,
  output fetch_entry_t  rdata_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam int            PW     = $clog2(DEPTH);
  localparam logic [PW-1:0] PONE   = PW'(1);
  localparam logic [CW-1:0] CONE   = CW'(1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_C);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PONE;
      if (do_push && !do_pop)      count_q <= count_q + CONE;
      else if (!do_push && do_pop) count_q <= count_q - CONE;
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: pipelined instruction-fetch front end.
// Issues reads over a waitrequest/readdatavalid bus, keeps at most DEPTH
// fetches in flight or buffered, drops stale responses after a redirect and
// hands {pc, instr} to decode over out_valid/out_ready. Reaching HALT_ADDR
// with nothing in flight drops `active` until reset.
//   clk, reset_n            clock, asynchronous active-low reset
//   clk_enable              gates launch, redirect and pop
//   instr_address/_read     registered read request
//   instr_waitrequest       bus stall
//   instr_readdatavalid/data in-order read response
//   redirect, redirect_pc   branch/jump taken and its target
//   out_valid/ready/pc/instr decode handoff
//   active                  low once halted
//   perf_fetched/discarded  counters, built only with FETCH_PERF_CNT_EN
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_enable,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic        instr_readdatavalid,
  input  logic [31:0] instr_readdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        active,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_discarded
);

  localparam int            CW      = cnt_w(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] CONE    = CW'(1);

  typedef enum logic {ST_RUN, ST_HALT} state_e;
  state_e state_q, state_d;

  logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          read_q, read_d;
  logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty, fifo_full;
  fetch_entry_t  fifo_head, push_entry;

  logic          run, accept, stalled, resp, do_redirect, launch, push, pop, halt_cond;
  logic [CW-1:0] acc_w, resp_w, read_w;
  logic [CW:0]   in_use;
  logic [31:0]   target;

  assign accept      = read_q & ~instr_waitrequest;
  assign stalled     = read_q & instr_waitrequest;
  assign resp        = instr_readdatavalid;
  assign do_redirect = redirect & clk_enable & run;
  assign target      = redirect_pc & ~32'h3;

  assign acc_w  = {{(CW-1){1'b0}}, accept};
  assign resp_w = {{(CW-1){1'b0}}, resp};
  assign read_w = {{(CW-1){1'b0}}, read_q};

  // Buffered + in flight + the request on the bus, each holding a FIFO slot.
  assign in_use = {1'b0, fifo_count} + {1'b0, outstanding_q} + {1'b0, read_w};

  assign launch = run & clk_enable & ~redirect & (fetch_pc_q != HALT_ADDR)
                & ~fifo_full & (in_use < DEPTH_C) & ~stalled;

  assign push       = resp & ~do_redirect & (discard_q == '0);
  assign pop        = out_valid & out_ready & clk_enable;
  assign push_entry = '{pc: resp_pc_q, instr: instr_readdata};
  assign halt_cond  = (fetch_pc_q == HALT_ADDR) & fifo_empty
                    & (outstanding_q == '0) & ~read_q;

  always_comb begin
    outstanding_d = outstanding_q + acc_w - resp_w;
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    read_d        = read_q;
    addr_d        = addr_q;

    // Every response still owed becomes stale, including a stalled request
    // that has yet to be accepted; already-marked entries are among them.
    if (do_redirect)                     discard_d = outstanding_q + read_w - resp_w;
    else if (resp && discard_q != '0)    discard_d = discard_q - CONE;

    if (do_redirect) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
    end else begin
      if (launch) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)   resp_pc_d  = resp_pc_q + 32'd4;
    end

    if (!stalled) begin
      read_d = launch;
      if (launch) addr_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q    <= RESET_VECTOR;
      resp_pc_q     <= RESET_VECTOR;
      addr_q        <= RESET_VECTOR;
      read_q        <= 1'b0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      addr_q        <= addr_d;
      read_q        <= read_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_RUN;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN && halt_cond) state_d = ST_HALT;
  end

  always_comb begin
    run    = (state_q == ST_RUN);
    active = run;
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (do_redirect),
    .wdata_i (push_entry),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign instr_read    = read_q;
  assign instr_address = addr_q;
  assign out_valid     = ~fifo_empty & run;
  assign out_pc        = fifo_head.pc;
  assign out_instr     = fifo_head.instr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_discarded_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched_q   <= '0;
      perf_discarded_q <= '0;
    end else begin
      if (push && perf_fetched_q != '1)
        perf_fetched_q <= perf_fetched_q + 32'd1;
      if (resp && !push && perf_discarded_q != '1)
        perf_discarded_q <= perf_discarded_q + 32'd1;
    end
  end

  assign perf_fetched   = perf_fetched_q;
  assign perf_discarded = perf_discarded_q;
`else
  assign perf_fetched   = '0;
  assign perf_discarded = '0;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed bench for mips_fetch_unit (DEPTH=4) with a
// fixed-latency in-order memory model driven on the falling clock edge.
`timescale 1ns/1ps
module tb_mips_fetch_unit;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_enable;
  logic [31:0] instr_address;
  logic        instr_read;
  logic        instr_waitrequest;
  logic        instr_readdatavalid = 1'b0;
  logic [31:0] instr_readdata = '0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        active;
  logic [31:0] perf_fetched;
  logic [31:0] perf_discarded;

  always #5 clk = ~clk;

  mips_fetch_unit #(
    .DEPTH        (4),
    .RESET_VECTOR (32'hBFC0_0000),
    .HALT_ADDR    (32'h0000_0000)
  ) u_dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .clk_enable          (clk_enable),
    .instr_address       (instr_address),
    .instr_read          (instr_read),
    .instr_waitrequest   (instr_waitrequest),
    .instr_readdatavalid (instr_readdatavalid),
    .instr_readdata      (instr_readdata),
    .redirect            (redirect),
    .redirect_pc         (redirect_pc),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_pc              (out_pc),
    .out_instr           (out_instr),
    .active              (active),
    .perf_fetched        (perf_fetched),
    .perf_discarded      (perf_discarded)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_F00F;
  endfunction

  // Memory model
  int unsigned lat = 1;
  int unsigned cyc = 0;
  int unsigned n_accepts = 0;
  logic        saw_zero = 1'b0;
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];

  initial begin
    forever begin
      @(negedge clk);
      instr_readdatavalid = 1'b0;
      instr_readdata      = '0;
      if (!reset_n) begin
        pend_addr.delete();
        pend_due.delete();
      end else begin
        if (pend_due.size() > 0 && pend_due[0] == cyc) begin
          instr_readdatavalid = 1'b1;
          instr_readdata      = word_of(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (instr_read && instr_address == 32'h0) saw_zero = 1'b1;
        if (instr_read && !instr_waitrequest) begin
          pend_addr.push_back(instr_address);
          pend_due.push_back(cyc + lat);
          n_accepts++;
        end
      end
      cyc++;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1ns after edge E0; the next posedge is E1.
  task automatic reset_dut(input int unsigned l, input logic rdy);
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    clk_enable = 1'b1; instr_waitrequest = 1'b0; out_ready = rdy;
    repeat (2) @(posedge clk);
    lat = l;
    #1 reset_n = 1'b1;
  endtask

  int unsigned acc0;

  initial begin
    reset_n = 1'b0; redirect = 1'b0; redirect_pc = '0;
    clk_enable = 1'b1; instr_waitrequest = 1'b0; out_ready = 1'b1;
    step(2);
    chk("rst_read", instr_read, 0);
    chk("rst_addr", instr_address, RV);
    chk("rst_valid", out_valid, 0);
    chk("rst_active", active, 1);
    chk("rst_perf_f", perf_fetched, 0);
    chk("rst_perf_d", perf_discarded, 0);

    // Streaming, zero wait, latency 1
    lat = 1; reset_n = 1'b1;
    step(1);
    chk("t1_read", instr_read, 1);
    chk("t1_addr0", instr_address, RV);
    step(1);
    for (int k = 3; k <= 8; k++) begin
      step(1);
      chk("t1_addr", instr_address, RV + 32'(4 * (k - 1)));
      chk("t1_valid", out_valid, 1);
      chk("t1_pc", out_pc, RV + 32'(4 * (k - 3)));
      chk("t1_instr", out_instr, word_of(RV + 32'(4 * (k - 3))));
    end
    chk("t1_active", active, 1);

    // Credit limit with decode stalled
    reset_dut(1, 1'b0);
    acc0 = n_accepts;
    step(4);
    chk("t2_addr_last", instr_address, RV + 32'hC);
    for (int k = 5; k <= 10; k++) begin
      step(1);
      chk("t2_read_off", instr_read, 0);
      chk("t2_addr_hold", instr_address, RV + 32'hC);
      chk("t2_valid", out_valid, 1);
      chk("t2_pc_hold", out_pc, RV);
    end
    chk("t2_accepts", n_accepts - acc0, 4);
`ifdef FETCH_PERF_CNT_EN
    chk("t2_perf_fetched", perf_fetched, 4);
`else
    chk("t2_perf_fetched_off", perf_fetched, 0);
`endif
    out_ready = 1'b1;
    step(1); chk("t2_pc_e11", out_pc, RV + 32'h4);
    step(1); chk("t2_pc_e12", out_pc, RV + 32'h8);
    step(1); chk("t2_pc_e13", out_pc, RV + 32'hC);
    step(1); chk("t2_pc_e14", out_pc, RV + 32'h10);

    // Asynchronous reset mid-cycle
    reset_n = 1'b0;
    #1;
    chk("arst_read", instr_read, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_addr", instr_address, RV);

    // Redirect with two responses in flight, latency 3
    reset_dut(3, 1'b1);
    step(2);
    redirect = 1'b1; redirect_pc = 32'h0040_0021;
    step(1);
    redirect = 1'b0;
    chk("t3_read_e3", instr_read, 0);
    chk("t3_valid_e3", out_valid, 0);
    step(1);
    chk("t3_read_e4", instr_read, 1);
    chk("t3_addr_e4", instr_address, 32'h0040_0020);
    step(3);
    chk("t3_valid_e7", out_valid, 0);
    step(1);
    chk("t3_valid_e8", out_valid, 1);
    chk("t3_pc_e8", out_pc, 32'h0040_0020);
    chk("t3_instr_e8", out_instr, word_of(32'h0040_0020));
`ifdef FETCH_PERF_CNT_EN
    chk("t3_perf_disc", perf_discarded, 2);
`else
    chk("t3_perf_disc_off", perf_discarded, 0);
`endif
    step(1);
    chk("t3_pc_e9", out_pc, 32'h0040_0024);

    // Stalled request with redirect during the stall
    reset_dut(1, 1'b1);
    instr_waitrequest = 1'b1;
    step(1);
    chk("t4_read_e1", instr_read, 1);
    chk("t4_addr_e1", instr_address, RV);
    step(1);
    chk("t4_addr_e2", instr_address, RV);
    redirect = 1'b1; redirect_pc = 32'h8000_1000;
    step(1);
    redirect = 1'b0;
    chk("t4_addr_e3", instr_address, RV);
    chk("t4_read_e3", instr_read, 1);
    step(1);
    chk("t4_addr_e4", instr_address, RV);
    instr_waitrequest = 1'b0;
    step(1);
    chk("t4_addr_e5", instr_address, 32'h8000_1000);
    chk("t4_read_e5", instr_read, 1);
    step(1);
    chk("t4_valid_e6", out_valid, 0);
    step(1);
    chk("t4_valid_e7", out_valid, 1);
    chk("t4_pc_e7", out_pc, 32'h8000_1000);
`ifdef FETCH_PERF_CNT_EN
    chk("t4_perf_disc", perf_discarded, 1);
`endif

    // Redirect to the halt address with one fetch in flight
    reset_dut(2, 1'b1);
    step(1);
    chk("t5_addr_e1", instr_address, RV);
    redirect = 1'b1; redirect_pc = 32'h0000_0003;
    step(1);
    redirect = 1'b0;
    chk("t5_read_e2", instr_read, 0);
    chk("t5_active_e2", active, 1);
    step(2);
    chk("t5_active_e4", active, 1);
    chk("t5_valid_e4", out_valid, 0);
    step(1);
    chk("t5_active_e5", active, 0);
    redirect = 1'b1; redirect_pc = 32'h0000_1000;
    step(1);
    redirect = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("t5_read_halt", instr_read, 0);
      chk("t5_active_halt", active, 0);
      chk("t5_valid_halt", out_valid, 0);
    end
    chk("t5_no_zero_req", saw_zero, 0);

    // clk_enable low while responses arrive
    reset_dut(2, 1'b1);
    step(2);
    clk_enable = 1'b0;
    step(1);
    chk("t6_read_e3", instr_read, 0);
    step(1);
    chk("t6_valid_e4", out_valid, 1);
    chk("t6_pc_e4", out_pc, RV);
    step(1);
    chk("t6_count_e5", 32'(u_dut.fifo_count), 2);
    chk("t6_pc_e5", out_pc, RV);
    chk("t6_addr_e5", instr_address, RV + 32'h4);
    step(1);
    chk("t6_pc_e6", out_pc, RV);
    chk("t6_read_e6", instr_read, 0);
    clk_enable = 1'b1;
    step(1);
    chk("t6_pc_e7", out_pc, RV + 32'h4);
    chk("t6_instr_e7", out_instr, word_of(RV + 32'h4));
    chk("t6_addr_e7", instr_address, RV + 32'h8);
    step(1);
    chk("t6_valid_e8", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
